// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 32-bit instruction words over a req/ack memory
// port, holds each word for the datapath until it is accepted, then advances
// the PC. Redirects override everything; a HALT opcode parks the unit.
//
// Handshakes:
//   imem side : imem_req is held high with a stable imem_addr until imem_ack.
//               imem_ack is a single-cycle pulse that qualifies imem_rdata,
//               and it only counts while imem_req is high.
//   datapath  : an instruction transfers on a cycle where
//               instr_valid && instr_ready (an "accept"). instr, opcode and
//               pc_out stay stable while instr_valid is high without accept.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] instr_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] count_q;
  // Low for the first cycle after reset so imem_req only rises on the first
  // edge after rst_n deasserts; a stale ack in that cycle is ignored.
  logic        armed_q;
  logic        fetch_ack;
  logic        accept;
  logic        load_instr;
  logic        unused_bits;

  // Low address bits of the redirect target are forced to zero.
  assign unused_bits = ^redirect_pc[1:0];

  assign imem_req    = armed_q && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign pc_out      = pc_out_q;
  assign instr_count = count_q;
  assign state_dbg   = state_q;

  assign fetch_ack = imem_req && imem_ack;
  assign accept    = instr_valid && instr_ready;

  // Next-state and PC logic; redirect has priority over every other event.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_instr = 1'b0;
    if (redirect) begin
      state_d = S_FETCH;
      pc_d    = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch_ack) begin
            load_instr = 1'b1;
            state_d    = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            if (opcode == HALT_OPCODE) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_q + 32'd4;
              state_d = S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State, PC and request-arming registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      armed_q <= 1'b1;
    end
  end

  // Held instruction word and its address, captured on a kept fetch ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= 32'd0;
      pc_out_q <= RESET_PC;
    end else if (load_instr) begin
      instr_q  <= imem_rdata;
      pc_out_q <= pc_q;
    end
  end

  // Accepted-instruction counter; an accept still counts under a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a table of per-cycle vectors for the
// straight-line fetch/issue/halt flow, then hand-written sequences for
// redirect corner cases and reset mid-fetch. A second instance with
// RESET_PC = 32'hFFFF_FFFC shares the inputs to cover PC wrap.
module tb_instr_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, instr, pc_out, instr_count;
  logic [5:0]  opcode;
  logic [1:0]  state_dbg;

  logic        imem_req2, instr_valid2, halted2;
  logic [31:0] imem_addr2, instr2, pc_out2, instr_count2;
  logic [5:0]  opcode2;
  logic [1:0]  state_dbg2;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_out(pc_out),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr2), .opcode(opcode2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready), .pc_out(pc_out2),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted2), .instr_count(instr_count2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready);
    imem_ack    = ack;
    imem_rdata  = rdata;
    instr_ready = ready;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_halt;
    logic [31:0] e_cnt;
    logic        chk2;
    logic [31:0] e_addr2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic e_halt, input logic [31:0] e_cnt,
                     input logic chk2, input logic [31:0] e_addr2);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_halt = e_halt; v.e_cnt = e_cnt;
    v.chk2 = chk2; v.e_addr2 = e_addr2;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_instr;

    // Rows: inputs for this cycle | outputs expected in this cycle (before edge).
    // Zero-wait memory, ready always high: one instruction per 2 cycles.
    add(0, 32'h0,         0, 0, 32'h0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h0);
    add(1, 32'h0000_0020, 1, 1, 32'h0, 0, 32'h0,         32'h0, 0, 0, 1, 32'hFFFF_FFFC);
    add(0, 32'h0,         1, 0, 32'h0, 1, 32'h0000_0020, 32'h0, 0, 0, 0, 32'h0);
    add(1, 32'h8C01_0004, 1, 1, 32'h4, 0, 32'h0,         32'h0, 0, 1, 1, 32'h0);
    add(0, 32'h0,         1, 0, 32'h4, 1, 32'h8C01_0004, 32'h4, 0, 1, 0, 32'h0);
    add(1, 32'hAC01_0008, 1, 1, 32'h8, 0, 32'h0,         32'h0, 0, 2, 1, 32'h4);
    add(0, 32'h0,         1, 0, 32'h8, 1, 32'hAC01_0008, 32'h8, 0, 2, 0, 32'h0);
    // Ack delayed 3 cycles: address held at 0xC.
    add(0, 32'h0,         0, 1, 32'hC, 0, 32'h0,         32'h0, 0, 3, 0, 32'h0);
    add(0, 32'h0,         0, 1, 32'hC, 0, 32'h0,         32'h0, 0, 3, 0, 32'h0);
    add(0, 32'h0,         0, 1, 32'hC, 0, 32'h0,         32'h0, 0, 3, 0, 32'h0);
    add(1, 32'h1234_5678, 0, 1, 32'hC, 0, 32'h0,         32'h0, 0, 3, 0, 32'h0);
    // Ready low 4 cycles: word and pc_out held.
    add(0, 32'h0,         0, 0, 32'hC, 1, 32'h1234_5678, 32'hC, 0, 3, 0, 32'h0);
    add(0, 32'h0,         0, 0, 32'hC, 1, 32'h1234_5678, 32'hC, 0, 3, 0, 32'h0);
    add(0, 32'h0,         0, 0, 32'hC, 1, 32'h1234_5678, 32'hC, 0, 3, 0, 32'h0);
    add(0, 32'h0,         0, 0, 32'hC, 1, 32'h1234_5678, 32'hC, 0, 3, 0, 32'h0);
    add(0, 32'h0,         1, 0, 32'hC, 1, 32'h1234_5678, 32'hC, 0, 3, 0, 32'h0);
    // HALT word at 0x10.
    add(1, 32'hFC00_0000, 0, 1, 32'h10, 0, 32'h0,         32'h0,  0, 4, 0, 32'h0);
    add(0, 32'h0,         1, 0, 32'h10, 1, 32'hFC00_0000, 32'h10, 0, 4, 0, 32'h0);
    add(0, 32'h0,         0, 0, 32'h10, 0, 32'h0,         32'h0,  1, 5, 0, 32'h0);

    // Reset state.
    drive(0, 32'h0, 0);
    step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Table-driven run.
    for (int i = 0; i < vq.size(); i++) begin
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vq[i].e_valid});
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vq[i].e_halt});
      chk($sformatf("v%0d_count", i), instr_count, vq[i].e_cnt);
      if (vq[i].e_valid) begin
        exp_instr = vq[i].e_instr;
        chk($sformatf("v%0d_instr", i), instr, exp_instr);
        chk($sformatf("v%0d_opcode", i), {26'd0, opcode}, {26'd0, exp_instr[31:26]});
        chk($sformatf("v%0d_pc_out", i), pc_out, vq[i].e_pc);
      end
      if (vq[i].chk2) begin
        chk($sformatf("v%0d_wrap_addr", i), imem_addr2, vq[i].e_addr2);
      end
      drive(vq[i].ack, vq[i].rdata, vq[i].ready);
      step();
    end
    drive(0, 32'h0, 0);

    // Parked on HALT: no requests for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      step();
    end

    // Redirect out of HALT to 0x40.
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_req", {31'd0, imem_req}, 32'd1);
    chk("unhalt_addr", imem_addr, 32'h40);
    chk("unhalt_count", instr_count, 32'd5);
    drive(1, 32'h0000_0001, 0);
    step();
    drive(0, 32'h0, 0);
    chk("f40_valid", {31'd0, instr_valid}, 32'd1);
    chk("f40_instr", instr, 32'h0000_0001);
    chk("f40_pc_out", pc_out, 32'h40);

    // Redirect to 0x103 in ISSUE with a simultaneous accept.
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    instr_ready = 1'b0; redirect = 1'b0;
    chk("rdacc_req", {31'd0, imem_req}, 32'd1);
    chk("rdacc_addr", imem_addr, 32'h100);
    chk("rdacc_valid", {31'd0, instr_valid}, 32'd0);
    chk("rdacc_count", instr_count, 32'd6);

    // Redirect coincident with imem_ack: rdata dropped.
    drive(1, 32'hDEAD_BEEF, 0);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    drive(0, 32'h0, 0);
    redirect = 1'b0;
    chk("rdack_valid", {31'd0, instr_valid}, 32'd0);
    chk("rdack_req", {31'd0, imem_req}, 32'd1);
    chk("rdack_addr", imem_addr, 32'h200);
    chk("rdack_instr", instr, 32'h0000_0001);
    step();
    chk("rdack_valid2", {31'd0, instr_valid}, 32'd0);
    drive(1, 32'h0000_0002, 0);
    step();
    drive(0, 32'h0, 1);
    chk("f200_valid", {31'd0, instr_valid}, 32'd1);
    chk("f200_instr", instr, 32'h0000_0002);
    chk("f200_pc_out", pc_out, 32'h200);
    step();
    drive(0, 32'h0, 0);
    chk("f204_addr", imem_addr, 32'h204);
    chk("f204_count", instr_count, 32'd7);
    chk("f204_req", {31'd0, imem_req}, 32'd1);

    // Reset pulsed mid-FETCH: outputs return to reset values immediately.
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_instr", instr, 32'h0);
    chk("mrst_pc_out", pc_out, 32'h0);
    chk("mrst_halted", {31'd0, halted}, 32'd0);
    chk("mrst_count", instr_count, 32'd0);
    drive(1, 32'h0000_0BAD, 0);
    step();
    rst_n = 1'b1;
    // Stale ack still high in the first cycle after release.
    step();
    drive(0, 32'h0, 0);
    chk("stale_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_req", {31'd0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0);
    step();
    chk("stale_valid2", {31'd0, instr_valid}, 32'd0);
    chk("stale_instr", instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
